// File: rtl/iterative_divider.sv
// Iterative 32-bit restoring divider for DIV/DIVU/REM/REMU, one quotient bit per cycle.
// Define DIVIDER_FAST_PATH_EN to resolve divide-by-zero and signed overflow without iterating.
package iterative_divider_pkg;
  typedef enum logic [1:0] {
    D_IDLE,
    D_INIT,
    D_CALC,
    D_SIGN
  } div_states_e;
endpackage

module iterative_divider
  import iterative_divider_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        start_i,
  input  logic        kill_i,
  input  logic        signed_i,
  input  logic        rem_i,
  input  logic [31:0] dividend_i,
  input  logic [31:0] divisor_i,
  output logic        hold_o,
  output logic        valid_o,
  output logic [31:0] result_o
);

  div_states_e state_q, state_d;

  logic [31:0] dvd_q, dvd_d;
  logic [31:0] dvs_q, dvs_d;
  logic [31:0] mag_b_q, mag_b_d;
  logic [31:0] quo_q, quo_d;
  logic [31:0] acc_q, acc_d;
  logic [31:0] res_q, res_d;
  logic [4:0]  cnt_q, cnt_d;
  logic        sgn_q, sgn_d;
  logic        sel_rem_q, sel_rem_d;
  logic        neg_a_q, neg_a_d;
  logic        neg_b_q, neg_b_d;
  logic        valid_q, valid_d;

  logic        a_neg;
  logic        b_neg;
  logic [31:0] a_mag;
  logic [31:0] b_mag;
  logic [32:0] shift;
  logic [32:0] diff;
  logic        div_zero;
  logic        ovf;
  logic [31:0] q_fix;
  logic [31:0] r_fix;
  logic [31:0] q_final;
  logic [31:0] r_final;

  assign a_neg = sgn_q & dvd_q[31];
  assign b_neg = sgn_q & dvs_q[31];
  assign a_mag = a_neg ? (32'd0 - dvd_q)
                       : dvd_q;
  assign b_mag = b_neg ? (32'd0 - dvs_q)
                       : dvs_q;

  // Remainder stays below the divisor, so one
  // extra bit is enough to see the borrow.
  assign shift = {acc_q, quo_q[31]};
  assign diff  = shift - {1'b0, mag_b_q};

  assign div_zero = (dvs_q == 32'd0);
  assign ovf      = sgn_q
                  & (dvd_q == 32'h8000_0000)
                  & (dvs_q == 32'hFFFF_FFFF);

  assign q_fix = (neg_a_q ^ neg_b_q)
               ? (32'd0 - quo_q) : quo_q;
  assign r_fix = neg_a_q
               ? (32'd0 - acc_q) : acc_q;

  assign q_final = div_zero ? 32'hFFFF_FFFF
                 : ovf      ? 32'h8000_0000
                 : q_fix;
  assign r_final = div_zero ? dvd_q
                 : ovf      ? 32'd0
                 : r_fix;

  always_comb begin
    state_d   = state_q;
    dvd_d     = dvd_q;
    dvs_d     = dvs_q;
    mag_b_d   = mag_b_q;
    quo_d     = quo_q;
    acc_d     = acc_q;
    res_d     = res_q;
    cnt_d     = cnt_q;
    sgn_d     = sgn_q;
    sel_rem_d = sel_rem_q;
    neg_a_d   = neg_a_q;
    neg_b_d   = neg_b_q;
    valid_d   = 1'b0;

    if (kill_i) begin
      state_d = D_IDLE;
    end else begin
      unique case (state_q)
        D_IDLE: begin
          if (start_i) begin
            dvd_d     = dividend_i;
            dvs_d     = divisor_i;
            sgn_d     = signed_i;
            sel_rem_d = rem_i;
            state_d   = D_INIT;
          end
        end
        D_INIT: begin
          neg_a_d = a_neg;
          neg_b_d = b_neg;
          quo_d   = a_mag;
          mag_b_d = b_mag;
          acc_d   = 32'd0;
          cnt_d   = 5'd31;
          state_d = D_CALC;
`ifdef DIVIDER_FAST_PATH_EN
          if (div_zero || ovf) begin
            state_d = D_SIGN;
          end
`endif
        end
        D_CALC: begin
          if (!diff[32]) begin
            acc_d = diff[31:0];
            quo_d = {quo_q[30:0], 1'b1};
          end else begin
            acc_d = shift[31:0];
            quo_d = {quo_q[30:0], 1'b0};
          end
          cnt_d = cnt_q - 5'd1;
          if (cnt_q == 5'd0) begin
            state_d = D_SIGN;
          end
        end
        D_SIGN: begin
          res_d   = sel_rem_q ? r_final
                              : q_final;
          valid_d = 1'b1;
          state_d = D_IDLE;
        end
        default: begin
          state_d = D_IDLE;
        end
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= D_IDLE;
      dvd_q     <= 32'd0;
      dvs_q     <= 32'd0;
      mag_b_q   <= 32'd0;
      quo_q     <= 32'd0;
      acc_q     <= 32'd0;
      res_q     <= 32'd0;
      cnt_q     <= 5'd0;
      sgn_q     <= 1'b0;
      sel_rem_q <= 1'b0;
      neg_a_q   <= 1'b0;
      neg_b_q   <= 1'b0;
      valid_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      dvd_q     <= dvd_d;
      dvs_q     <= dvs_d;
      mag_b_q   <= mag_b_d;
      quo_q     <= quo_d;
      acc_q     <= acc_d;
      res_q     <= res_d;
      cnt_q     <= cnt_d;
      sgn_q     <= sgn_d;
      sel_rem_q <= sel_rem_d;
      neg_a_q   <= neg_a_d;
      neg_b_q   <= neg_b_d;
      valid_q   <= valid_d;
    end
  end

  assign hold_o = ((state_q == D_IDLE)
                   & start_i & ~kill_i)
                | (state_q != D_IDLE);

  assign valid_o  = valid_q;
  assign result_o = res_q;

endmodule

// File: tb/tb_iterative_divider.sv
// Self-checking bench for iterative_divider: transaction-level model
// checked every cycle, plus directed vectors with literal expectations.
module tb_iterative_divider;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        start_i = 1'b0;
  logic        kill_i = 1'b0;
  logic        signed_i = 1'b0;
  logic        rem_i = 1'b0;
  logic [31:0] dividend_i = 32'd0;
  logic [31:0] divisor_i = 32'd0;
  logic        hold_o;
  logic        valid_o;
  logic [31:0] result_o;

  iterative_divider dut (
    .clk        (clk),
    .reset      (reset),
    .start_i    (start_i),
    .kill_i     (kill_i),
    .signed_i   (signed_i),
    .rem_i      (rem_i),
    .dividend_i (dividend_i),
    .divisor_i  (divisor_i),
    .hold_o     (hold_o),
    .valid_o    (valid_o),
    .result_o   (result_o)
  );

  always #5 clk = ~clk;

`ifdef DIVIDER_FAST_PATH_EN
  localparam int LAT_SPECIAL = 2;
`else
  localparam int LAT_SPECIAL = 34;
`endif

  int n_checks = 0;
  int n_fail = 0;

  task automatic chk(input string name,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h",
               name, got, exp);
    end
  endtask

  function automatic logic [31:0] model(
    input logic [31:0] a,
    input logic [31:0] b,
    input logic s,
    input logic r);
    logic [31:0] q;
    logic [31:0] m;
    if (b == 32'd0) begin
      q = 32'hFFFF_FFFF;
      m = a;
    end else if (s && a == 32'h8000_0000
                 && b == 32'hFFFF_FFFF) begin
      q = 32'h8000_0000;
      m = 32'd0;
    end else if (s) begin
      q = $signed(a) / $signed(b);
      m = $signed(a) % $signed(b);
    end else begin
      q = a / b;
      m = a % b;
    end
    return r ? m : q;
  endfunction

  function automatic int exp_lat(
    input logic [31:0] a,
    input logic [31:0] b,
    input logic s);
    if (b == 32'd0) return LAT_SPECIAL;
    if (s && a == 32'h8000_0000
        && b == 32'hFFFF_FFFF) return LAT_SPECIAL;
    return 34;
  endfunction

  // Transaction-level model: busy flag,
  // cycles to completion, and held result.
  bit          m_busy = 1'b0;
  int          m_cnt = 0;
  logic [31:0] m_pend = 32'd0;
  logic [31:0] m_res = 32'd0;
  bit          m_valid = 1'b0;

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      m_busy  <= 1'b0;
      m_cnt   <= 0;
      m_res   <= 32'd0;
      m_valid <= 1'b0;
    end else begin
      m_valid <= 1'b0;
      if (kill_i) begin
        m_busy <= 1'b0;
      end else if (m_busy) begin
        m_cnt <= m_cnt - 1;
        if (m_cnt == 1) begin
          m_busy  <= 1'b0;
          m_res   <= m_pend;
          m_valid <= 1'b1;
        end
      end else if (start_i) begin
        m_busy <= 1'b1;
        m_cnt  <= exp_lat(dividend_i,
                          divisor_i, signed_i);
        m_pend <= model(dividend_i, divisor_i,
                        signed_i, rem_i);
      end
    end
  end

  always @(negedge clk) begin
    chk("cyc_hold", {31'd0, hold_o},
        {31'd0, m_busy | (start_i & ~kill_i)});
    chk("cyc_valid", {31'd0, valid_o},
        {31'd0, m_valid});
    chk("cyc_result", result_o, m_res);
  end

  task automatic issue(input logic [31:0] a,
                       input logic [31:0] b,
                       input logic s,
                       input logic r);
    dividend_i = a;
    divisor_i  = b;
    signed_i   = s;
    rem_i      = r;
    start_i    = 1'b1;
    @(posedge clk);
    #2 start_i = 1'b0;
  endtask

  task automatic wait_valid(output int lat);
    lat = 0;
    for (int i = 0; i < 100; i++) begin
      @(posedge clk);
      lat++;
      #1;
      if (valid_o) break;
    end
    if (!valid_o) begin
      n_checks++;
      n_fail++;
      $display("FAIL wait_valid: got timeout expected valid_o");
    end
    #1;
  endtask

  localparam int NV = 13;
  logic [31:0] va[NV] = '{
    32'd100, 32'd100, 32'hFFFF_FFF9,
    32'hFFFF_FFF9, 32'd5, 32'd5, 32'd5,
    32'h8000_0000, 32'h8000_0000,
    32'h8000_0000, 32'hFFFF_FFF9, 32'd7,
    32'hFFFF_FFFF};
  logic [31:0] vb[NV] = '{
    32'd7, 32'd7, 32'd2, 32'd2, 32'd0,
    32'd0, 32'd0, 32'hFFFF_FFFF,
    32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd0,
    32'hFFFF_FFFE, 32'd1};
  logic vs[NV] = '{1'b0, 1'b0, 1'b1, 1'b1,
    1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0,
    1'b1, 1'b1, 1'b0};
  logic vr[NV] = '{1'b0, 1'b1, 1'b0, 1'b1,
    1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0,
    1'b1, 1'b0, 1'b0};
  logic vsp[NV] = '{1'b0, 1'b0, 1'b0, 1'b0,
    1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0,
    1'b1, 1'b0, 1'b0};
  logic [31:0] vexp[NV] = '{
    32'd14, 32'd2, 32'hFFFF_FFFD,
    32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd5,
    32'hFFFF_FFFF, 32'h8000_0000, 32'd0,
    32'd0, 32'hFFFF_FFF9, 32'hFFFF_FFFD,
    32'hFFFF_FFFF};

  initial begin
    int lat;
    @(posedge clk);
    #1;
    chk("rst_valid", {31'd0, valid_o}, 32'd0);
    chk("rst_result", result_o, 32'd0);
    chk("rst_hold", {31'd0, hold_o}, 32'd0);
    @(posedge clk);
    #2 reset = 1'b0;

    for (int i = 0; i < NV; i++) begin
      chk($sformatf("model_pin%0d", i),
          model(va[i], vb[i], vs[i], vr[i]),
          vexp[i]);
    end

    for (int i = 0; i < NV; i++) begin
      issue(va[i], vb[i], vs[i], vr[i]);
      wait_valid(lat);
      chk($sformatf("vec%0d_result", i),
          result_o, vexp[i]);
      chk($sformatf("vec%0d_latency", i),
          lat, vsp[i] ? LAT_SPECIAL : 34);
      @(posedge clk);
      #2;
    end

    // kill wins over start in idle
    start_i = 1'b1;
    kill_i  = 1'b1;
    #1 chk("kill_prio_hold",
           {31'd0, hold_o}, 32'd0);
    @(posedge clk);
    #2 start_i = 1'b0;
    kill_i = 1'b0;
    @(posedge clk);
    #1 chk("kill_prio_idle",
           {31'd0, hold_o}, 32'd0);
    #1;

    // kill during the tenth calc step
    issue(32'd1000, 32'd3, 1'b0, 1'b0);
    repeat (11) @(posedge clk);
    #2 kill_i = 1'b1;
    @(posedge clk);
    #1 chk("kill_hold", {31'd0, hold_o}, 32'd0);
    chk("kill_valid", {31'd0, valid_o}, 32'd0);
    chk("kill_result", result_o, 32'hFFFF_FFFF);
    #1 kill_i = 1'b0;
    @(posedge clk);
    #2 issue(32'd1000, 32'd3, 1'b0, 1'b0);
    wait_valid(lat);
    chk("after_kill_result", result_o, 32'd333);
    chk("after_kill_latency", lat, 34);
    @(posedge clk);
    #2;

    // start while busy is ignored
    issue(32'd100, 32'd7, 1'b0, 1'b0);
    repeat (5) @(posedge clk);
    #2 dividend_i = 32'd9;
    divisor_i = 32'd3;
    start_i = 1'b1;
    @(posedge clk);
    #2 start_i = 1'b0;
    wait_valid(lat);
    chk("busy_start_result", result_o, 32'd14);
    chk("busy_start_latency", lat, 28);
    @(posedge clk);
    #2;

    // back-to-back from the valid cycle
    issue(32'hFFFF_FFF9, 32'd2, 1'b1, 1'b0);
    wait_valid(lat);
    chk("b2b_first", result_o, 32'hFFFF_FFFD);
    issue(32'd100, 32'd7, 1'b0, 1'b1);
    wait_valid(lat);
    chk("b2b_second", result_o, 32'd2);
    chk("b2b_latency", lat, 34);
    @(posedge clk);
    #2;

    // reset in the middle of calc
    issue(32'd100, 32'd7, 1'b0, 1'b0);
    repeat (10) @(posedge clk);
    #2 reset = 1'b1;
    #1 chk("midrst_valid",
           {31'd0, valid_o}, 32'd0);
    chk("midrst_result", result_o, 32'd0);
    chk("midrst_hold", {31'd0, hold_o}, 32'd0);
    @(posedge clk);
    @(posedge clk);
    #1 reset = 1'b0;
    issue(32'd5, 32'd0, 1'b0, 1'b1);
    wait_valid(lat);
    chk("postrst_result", result_o, 32'd5);
    chk("postrst_latency", lat, LAT_SPECIAL);

    repeat (3) @(posedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/iterative_divider.md
ITERATIVE_DIVIDER -- requirements
Module: iterative_divider

Interface
REQ-001 SHALL have parameters: none; operand width is fixed at 32 bits.
REQ-002 SHALL have port: clk  input  1  sole clock, rising-edge.
REQ-003 SHALL have port: reset  input  1  asynchronous, active-high reset.
REQ-004 SHALL have port: start_i  input  1  request a new division; sampled only in D_IDLE.
REQ-005 SHALL have port: kill_i  input  1  pipeline flush; aborts any operation in progress.
REQ-006 SHALL have port: signed_i  input  1  1 = DIV/REM, 0 = DIVU/REMU.
REQ-007 SHALL have port: rem_i  input  1  1 = return remainder, 0 = return quotient.
REQ-008 SHALL have ports: dividend_i, divisor_i  input  32  operands, sampled with start_i.
REQ-009 SHALL have port: hold_o  output  1  stall request to the execute stage.
REQ-010 SHALL have port: valid_o  output  1  one-cycle result-ready pulse.
REQ-011 SHALL have port: result_o  output  32  quotient or remainder.

Function
REQ-012 SHALL implement a 4-state FSM using the package type div_states_e: D_IDLE, D_INIT, D_CALC, D_SIGN.
REQ-013 D_IDLE: start_i=1 and kill_i=0 SHALL register operands, signed_i and rem_i, then go to D_INIT.
REQ-014 D_INIT: SHALL store operand magnitudes (two's-complement negation when signed_i and MSB=1), record sign flags, clear remainder, load count=31, then go to D_CALC.
REQ-015 D_CALC: SHALL perform one restoring radix-2 step per cycle (shift remainder:quotient left by 1, subtract divisor, keep the result if non-negative and set quotient bit) and go to D_SIGN after the step with count=0, i.e. exactly 32 cycles.
REQ-016 D_SIGN: SHALL negate the quotient if the dividend and divisor signs differ (signed only), SHALL negate the remainder if the dividend was negative (signed only), SHALL register the selected result into result_o, and SHALL go to D_IDLE.
REQ-017 Divide by zero SHALL produce quotient 0xFFFFFFFF and remainder = original dividend, for both signed and unsigned operations.
REQ-018 Signed overflow (0x80000000 / 0xFFFFFFFF) SHALL produce quotient 0x80000000 and remainder 0.
REQ-019 valid_o SHALL be 1 for exactly the single cycle after D_SIGN, i.e. 34 cycles after the start edge in the normal path.
REQ-020 result_o SHALL hold its value until the next D_SIGN state.
REQ-021 hold_o SHALL be combinational: (D_IDLE and start_i and not kill_i) or state in {D_INIT, D_CALC, D_SIGN}.
REQ-022 start_i SHALL be accepted in the same cycle that valid_o=1; start_i in any other state SHALL be ignored.
REQ-023 kill_i=1 in any state SHALL force D_IDLE on the next edge with no valid_o pulse and no change to result_o; kill_i has priority over start_i.

Reset
REQ-024 reset SHALL asynchronously force state=D_IDLE, valid_o=0, result_o=0, and all internal registers to 0; hold_o follows from state.
REQ-025 Reset during D_CALC SHALL discard the operation; the first cycle after deassertion SHALL accept start_i.

Configuration
REQ-026 When DIVIDER_FAST_PATH_EN is defined, divide-by-zero and signed overflow SHALL be detected in D_INIT, which then goes directly to D_SIGN, giving valid_o 2 cycles after the start edge.
REQ-027 When DIVIDER_FAST_PATH_EN is undefined, these cases SHALL take the full 34-cycle path; results SHALL be identical in both builds, since REQ-017 and REQ-018 are applied as overrides in D_SIGN.

Verification
REQ-028 DIVU 100/7, quotient selected -> valid_o at cycle 34, result_o=14; the same operands with rem_i=1 -> result_o=2.
REQ-029 DIV -7/2 -> quotient 0xFFFFFFFD (-3); REM -7/2 -> remainder 0xFFFFFFFF (-1).
REQ-030 DIV 5/0 -> 0xFFFFFFFF; REM 5/0 -> 5; run in both builds, with latency 2 when DIVIDER_FAST_PATH_EN is defined and 34 otherwise.
REQ-031 DIV 0x80000000/0xFFFFFFFF -> 0x80000000; REM of the same operands -> 0.
REQ-032 kill_i at cycle 10 of D_CALC -> D_IDLE next cycle, hold_o=0, no valid_o, result_o unchanged; a new start_i two cycles later completes correctly.
REQ-033 start_i asserted in the valid_o cycle, back-to-back -> second operation accepted with no idle gap; reset asserted mid-D_CALC -> all outputs 0 immediately.
